// File: rtl/lc256_pkg.sv
// lc256_pkg: shared definitions for the lc256 DMA controller.
//   - register offsets of the CPU-visible window (RA values)
//   - bit positions inside the CTRL register
//   - the controller state enumeration
package lc256_pkg;

  localparam logic [2:0] REG_SRC_L = 3'd0;
  localparam logic [2:0] REG_SRC_H = 3'd1;
  localparam logic [2:0] REG_DST_L = 3'd2;
  localparam logic [2:0] REG_DST_H = 3'd3;
  localparam logic [2:0] REG_LEN   = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_CLR  = 1;
  localparam int CTRL_HOLD_SRC = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/lc256_dma.sv
// lc256_dma: bus-master memory-to-memory byte copier.
// The CPU programs SRC/DST/LEN/CTRL through the MMU write strobe; START
// requests the bus (_DMA low), and once BA is granted the block alternates
// one read cycle and one write cycle per byte, then releases the bus and
// raises IRQ.
// Ports:
//   PHI2, RESET       clock and synchronous active-high reset
//   _CSW, RA, D_IN    register write strobe/select/data (D_IN also read data)
//   BA                bus grant from the MMU
//   _DMA              active-low bus request
//   A_OUT, D_OUT      DMA address and write data
//   R_W_OUT, BUS_OE   DMA read(1)/write(0) and bus driver enable
//   IRQ, BUSY         completion/abort flag and transfer-in-progress
// Optional build macro LC256_DMA_FILL_EN: CTRL bit2 HOLD_SRC freezes the
// source pointer so one byte is replicated (memory fill). Without the macro
// the bit is ignored.
module lc256_dma
  import lc256_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic        PHI2,
  input  logic        RESET,
  input  logic        _CSW,
  input  logic [2:0]  RA,
  input  logic [7:0]  D_IN,
  input  logic        BA,
  output logic        _DMA,
  output logic [15:0] A_OUT,
  output logic [7:0]  D_OUT,
  output logic        R_W_OUT,
  output logic        BUS_OE,
  output logic        IRQ,
  output logic        BUSY
);

  // Last value of the grant wait counter before the request is abandoned.
  localparam logic [15:0] WAIT_LAST =
    (REQ_TIMEOUT > 0) ? 16'(REQ_TIMEOUT - 1) : 16'd0;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [15:0]      src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [15:0]      srcp_q, srcp_d, dstp_q, dstp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic [15:0]      wait_q, wait_d;
  logic             irq_q, irq_d;
  logic             dma_n_q, dma_n_d;
  logic             bus_oe_q, bus_oe_d;
  logic             r_w_q, r_w_d;
  logic             busy_q, busy_d;
  logic [15:0]      a_out_q, a_out_d;
  logic [7:0]       d_out_q, d_out_d;

  logic ctrl_wr;
  logic hold_src;

  assign ctrl_wr = !_CSW && (RA == REG_CTRL);

`ifdef LC256_DMA_FILL_EN
  logic hold_src_q, hold_src_d;

  // HOLD_SRC is a persistent CTRL bit; it cannot change mid-transfer.
  always_comb begin
    hold_src_d = hold_src_q;
    if (ctrl_wr && !busy_q) begin
      hold_src_d = D_IN[CTRL_HOLD_SRC];
    end else begin
      hold_src_d = hold_src_q;
    end
  end

  // HOLD_SRC register.
  always_ff @(posedge PHI2) begin
    if (RESET) begin
      hold_src_q <= 1'b0;
    end else begin
      hold_src_q <= hold_src_d;
    end
  end

  assign hold_src = hold_src_q;
`else
  assign hold_src = 1'b0;
`endif

  // Register writes, transfer FSM and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    srcp_d   = srcp_q;
    dstp_d   = dstp_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    wait_d   = wait_q;
    irq_d    = irq_q;
    dma_n_d  = 1'b1;
    bus_oe_d = 1'b0;
    r_w_d    = 1'b1;
    busy_d   = 1'b0;
    a_out_d  = a_out_q;
    d_out_d  = d_out_q;

    // Programmed registers are frozen while a transfer is in progress.
    if (!_CSW && !busy_q) begin
      case (RA)
        REG_SRC_L: src_d[7:0]  = D_IN;
        REG_SRC_H: src_d[15:8] = D_IN;
        REG_DST_L: dst_d[7:0]  = D_IN;
        REG_DST_H: dst_d[15:8] = D_IN;
        REG_LEN:   len_d       = CNT_W'(D_IN);
        default:   len_d       = len_q;
      endcase
    end else begin
      len_d = len_q;
    end

    if (ctrl_wr && D_IN[CTRL_IRQ_CLR]) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_wr && D_IN[CTRL_START]) begin
          state_d = REQ;
          srcp_d  = src_q;
          dstp_d  = dst_q;
          cnt_d   = len_q;   // 0 wraps through all ones: 2^CNT_W bytes
          wait_d  = 16'd0;
          irq_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (BA) begin
          state_d = RD;
        end else if ((REQ_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
          state_d = DONE;
          irq_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      RD: begin
        // Without BA the bus cycle is stretched: nothing advances.
        if (BA) begin
          data_d  = D_IN;
          state_d = WR;
        end else begin
          state_d = RD;
        end
      end
      WR: begin
        if (BA) begin
          dstp_d = dstp_q + 16'd1;
          srcp_d = hold_src ? srcp_q : (srcp_q + 16'd1);
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
            irq_d   = 1'b1;
          end else begin
            state_d = RD;
          end
        end else begin
          state_d = WR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered: decode them from the state being entered.
    case (state_d)
      REQ: begin
        dma_n_d = 1'b0;
        busy_d  = 1'b1;
      end
      RD: begin
        dma_n_d  = 1'b0;
        busy_d   = 1'b1;
        bus_oe_d = 1'b1;
        r_w_d    = 1'b1;
        a_out_d  = srcp_d;
      end
      WR: begin
        dma_n_d  = 1'b0;
        busy_d   = 1'b1;
        bus_oe_d = 1'b1;
        r_w_d    = 1'b0;
        a_out_d  = dstp_d;
        d_out_d  = data_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge PHI2) begin
    if (RESET) begin
      state_q  <= IDLE;
      src_q    <= 16'd0;
      dst_q    <= 16'd0;
      len_q    <= '0;
      srcp_q   <= 16'd0;
      dstp_q   <= 16'd0;
      cnt_q    <= '0;
      data_q   <= 8'd0;
      wait_q   <= 16'd0;
      irq_q    <= 1'b0;
      dma_n_q  <= 1'b1;
      bus_oe_q <= 1'b0;
      r_w_q    <= 1'b1;
      busy_q   <= 1'b0;
      a_out_q  <= 16'd0;
      d_out_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      srcp_q   <= srcp_d;
      dstp_q   <= dstp_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      wait_q   <= wait_d;
      irq_q    <= irq_d;
      dma_n_q  <= dma_n_d;
      bus_oe_q <= bus_oe_d;
      r_w_q    <= r_w_d;
      busy_q   <= busy_d;
      a_out_q  <= a_out_d;
      d_out_q  <= d_out_d;
    end
  end

  assign _DMA    = dma_n_q;
  assign BUS_OE  = bus_oe_q;
  assign R_W_OUT = r_w_q;
  assign A_OUT   = a_out_q;
  assign D_OUT   = d_out_q;
  assign IRQ     = irq_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_lc256_dma.sv
// tb_lc256_dma: directed/randomized bench for lc256_dma.
// A 64 KiB memory answers DMA reads; a small MMU model grants BA after a
// programmable delay (optionally dropping it at random). Each transfer is
// predicted by a byte-by-byte ascending copy over a snapshot of memory and
// compared against the observed bus cycles and final memory contents.
// Build with LC256_DMA_FILL_EN defined to expect HOLD_SRC fill behaviour.
module tb_lc256_dma;

  logic        phi2 = 1'b0;
  logic        reset, csw_n, ba, dma_n, r_w, bus_oe, irq, busy;
  logic [2:0]  ra;
  logic [7:0]  cpu_d, d_in, d_out;
  logic [15:0] a_out;

  logic [7:0]  mem  [0:65535];
  logic [7:0]  refm [0:65535];

  int checks = 0;
  int failures = 0;
  int gdelay = 0;
  bit ba_drop = 1'b0;
  bit ba_block = 1'b0;

  logic [15:0] rd_q[$], wa_q[$], e_rd[$], e_wa[$];
  logic [7:0]  wd_q[$], e_wd[$];

`ifdef LC256_DMA_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  always #5 phi2 = ~phi2;

  assign d_in = (bus_oe && r_w) ? mem[a_out] : cpu_d;

  lc256_dma dut (
    .PHI2(phi2), .RESET(reset), ._CSW(csw_n), .RA(ra), .D_IN(d_in), .BA(ba),
    ._DMA(dma_n), .A_OUT(a_out), .D_OUT(d_out), .R_W_OUT(r_w),
    .BUS_OE(bus_oe), .IRQ(irq), .BUSY(busy)
  );

  // Bus monitor and memory: a cycle completes on a rising edge with BA high.
  always @(posedge phi2) begin
    if (!reset && bus_oe && ba) begin
      if (r_w) begin
        rd_q.push_back(a_out);
      end else begin
        wa_q.push_back(a_out);
        wd_q.push_back(d_out);
        mem[a_out] = d_out;
      end
    end
  end

  // MMU model: grant after gdelay cycles of request, optionally flaky.
  always @(negedge phi2) begin
    int gcnt;
    if (dma_n || ba_block) begin
      ba = 1'b0;
      gcnt = 0;
    end else if (gcnt >= gdelay) begin
      ba = ba_drop ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      gcnt++;
      ba = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [2:0] r, input logic [7:0] v);
    @(negedge phi2);
    csw_n = 1'b0; ra = r; cpu_d = v;
    @(negedge phi2);
    csw_n = 1'b1; ra = 3'd7; cpu_d = 8'h00;
  endtask

  task automatic run_xfer(input bit prog, input logic [15:0] src, input logic [15:0] dst,
                          input int len, input int gd, input bit drop, input bit hold,
                          input string tag, output logic [15:0] last_wa);
    int n, cyc, active, bad_rd, bad_wa, bad_wd, bad_mem;
    bit hold_eff;
    logic [15:0] sa, da;
    n = (len == 0) ? 256 : len;
    hold_eff = hold & FILL;
    if (prog) begin
      cpu_wr(3'd0, src[7:0]);  cpu_wr(3'd1, src[15:8]);
      cpu_wr(3'd2, dst[7:0]);  cpu_wr(3'd3, dst[15:8]);
      cpu_wr(3'd4, 8'(len));
    end
    gdelay = gd; ba_drop = drop;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    e_rd.delete(); e_wa.delete(); e_wd.delete();
    for (int i = 0; i < 65536; i++) refm[i] = mem[i];
    // Reference: ascending byte-by-byte copy, addresses wrap at 16 bits.
    for (int i = 0; i < n; i++) begin
      sa = hold_eff ? src : 16'(src + i);
      da = 16'(dst + i);
      e_rd.push_back(sa); e_wa.push_back(da); e_wd.push_back(refm[sa]);
      refm[da] = refm[sa];
    end
    cpu_wr(3'd5, {5'b00000, hold, 2'b01});
    chk({tag, "_req"}, dma_n, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_irq_clr_by_start"}, irq, 1'b0);
    cyc = 0; active = 0;
    while (irq !== 1'b1 && cyc < 3000) begin
      if (bus_oe) active++;
      @(negedge phi2);
      cyc++;
    end
    chk({tag, "_finished"}, cyc < 3000, 1'b1);
    chk({tag, "_dma_released"}, dma_n, 1'b1);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_oe_done"}, bus_oe, 1'b0);
    if (!drop) chk({tag, "_bus_cycles"}, active, 2 * n);
    chk({tag, "_rd_count"}, rd_q.size(), n);
    chk({tag, "_wr_count"}, wa_q.size(), n);
    bad_rd = 0; bad_wa = 0; bad_wd = 0; bad_mem = 0;
    for (int i = 0; i < n && i < rd_q.size(); i++) if (rd_q[i] !== e_rd[i]) bad_rd++;
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      if (wa_q[i] !== e_wa[i]) bad_wa++;
      if (wd_q[i] !== e_wd[i]) bad_wd++;
    end
    for (int i = 0; i < 65536; i++) if (mem[i] !== refm[i]) bad_mem++;
    chk({tag, "_rd_addr_errs"}, bad_rd, 0);
    chk({tag, "_wr_addr_errs"}, bad_wa, 0);
    chk({tag, "_wr_data_errs"}, bad_wd, 0);
    chk({tag, "_mem_errs"}, bad_mem, 0);
    last_wa = (wa_q.size() > 0) ? wa_q[wa_q.size() - 1] : 16'hDEAD;
  endtask

  initial begin
    logic [15:0] last, rs, rdst;
    int cyc, low, active;
    bit oe_seen;

    reset = 1'b1; csw_n = 1'b1; ra = 3'd7; cpu_d = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge phi2);
    chk("rst_dma", dma_n, 1'b1);
    chk("rst_oe", bus_oe, 1'b0);
    chk("rst_rw", r_w, 1'b1);
    chk("rst_a", a_out, 16'h0000);
    chk("rst_d", d_out, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Basic 4-byte copy with a 3-cycle grant delay.
    run_xfer(1'b1, 16'h2000, 16'h3000, 4, 3, 1'b0, 1'b0, "copy4", last);
    chk("copy4_last_wr", last, 16'h3003);

    // Random copies with BA dropping mid-transfer (stall behaviour).
    for (int k = 0; k < 3; k++) begin
      rs = 16'($urandom); rdst = 16'($urandom);
      run_xfer(1'b1, rs, rdst, $urandom_range(1, 40), $urandom_range(0, 6),
               1'b1, 1'b0, "rand", last);
    end

    // Overlapping forward copy propagates the first byte.
    run_xfer(1'b1, 16'h1000, 16'h1001, 20, 1, 1'b1, 1'b0, "overlap", last);

    // Source address wrap.
    run_xfer(1'b1, 16'hFFFE, 16'h7000, 3, 2, 1'b0, 1'b0, "wrap", last);
    chk("wrap_rd2", (rd_q.size() > 2) ? rd_q[2] : 16'h1234, 16'h0000);

    // LEN=0 is a 256-byte transfer.
    run_xfer(1'b1, 16'($urandom), 16'h4000, 0, 2, 1'b0, 1'b0, "len0", last);
    chk("len0_last_wr", last, 16'h40FF);

    // HOLD_SRC fill (behaves as a plain copy without the fill macro).
    mem[16'hE000] = 8'hAA;
    run_xfer(1'b1, 16'hE000, 16'h8000, 8, 2, 1'b0, 1'b1, "fill", last);

    // Grant never arrives: abort after REQ_TIMEOUT cycles.
    ba_block = 1'b1;
    cpu_wr(3'd4, 8'd5);
    cpu_wr(3'd5, 8'h01);
    cyc = 0; low = 0; oe_seen = 1'b0;
    while (dma_n === 1'b0 && cyc < 400) begin
      low++;
      if (bus_oe) oe_seen = 1'b1;
      @(negedge phi2);
      cyc++;
    end
    chk("to_req_cycles", low, 255);
    chk("to_no_oe", oe_seen, 1'b0);
    chk("to_irq", irq, 1'b1);
    chk("to_busy", busy, 1'b0);
    ba_block = 1'b0;
    cpu_wr(3'd5, 8'h02);
    chk("irq_clr", irq, 1'b0);

    // RESET while the second write cycle is on the bus.
    cpu_wr(3'd0, 8'h00); cpu_wr(3'd1, 8'h50);
    cpu_wr(3'd2, 8'h00); cpu_wr(3'd3, 8'h60);
    cpu_wr(3'd4, 8'd10);
    gdelay = 1; ba_drop = 1'b0;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    cpu_wr(3'd5, 8'h01);
    cyc = 0;
    while (!(bus_oe === 1'b1 && r_w === 1'b0 && wa_q.size() == 1) && cyc < 200) begin
      @(negedge phi2);
      cyc++;
    end
    chk("rst_reach_wr2", cyc < 200, 1'b1);
    reset = 1'b1;
    @(negedge phi2);
    chk("mid_rst_dma", dma_n, 1'b1);
    chk("mid_rst_oe", bus_oe, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rw", r_w, 1'b1);
    chk("mid_rst_a", a_out, 16'h0000);
    reset = 1'b0;
    active = 0;
    repeat (5) begin
      @(negedge phi2);
      if (bus_oe) active++;
    end
    chk("post_rst_idle", active, 0);
    chk("post_rst_wr_count", wa_q.size(), 1);

    // Registers were cleared: START alone copies 256 bytes at $0000.
    run_xfer(1'b0, 16'h0000, 16'h0000, 0, 2, 1'b0, 1'b0, "post_rst", last);
    chk("post_rst_last_wr", last, 16'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc256_dma.md
Name: lc256_dma

Overview:
- Bus-master DMA controller that drives the MMU's active-low DMA request and performs memory-to-memory byte copies while the CPU is halted.
- The CPU programs it through the I/O window using an active-low write chip-select from the MMU.
- Once the MMU reports bus grant (BA high), it drives the address, R/W and data buses one byte-cycle per PHI2 until the count expires.
- It then releases the DMA request and raises an interrupt flag.

Parameters:
- CNT_W, 8, transfer-length width; LEN=0 means 2^CNT_W bytes.
- REQ_TIMEOUT, 255, PHI2 cycles to wait for BA before aborting (0 = wait forever).

Ports:
- PHI2  input  1  system clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- _CSW  input  1  active-low register-write strobe from the MMU (valid while PHI2 high).
- RA  input  3  register select, CPU A[2:0].
- D_IN  input  8  data bus in: CPU write data, and DMA read data.
- BA  input  1  bus granted by the MMU (CPU halted, bus drivers released).
- _DMA  output  1  active-low DMA request to the MMU.
- A_OUT  output  16  DMA address.
- D_OUT  output  8  DMA write data.
- R_W_OUT  output  1  DMA read(1)/write(0).
- BUS_OE  output  1  enables the A_OUT/D_OUT/R_W_OUT drivers.
- IRQ  output  1  active-high completion/abort flag.
- BUSY  output  1  transfer in progress.

Behaviour:
- Reset values: _DMA=1, BUS_OE=0, R_W_OUT=1, A_OUT=0, D_OUT=0, IRQ=0, BUSY=0, all registers 0, state IDLE.
- RESET mid-transfer aborts immediately to the reset values; no further bus cycles occur.
- Register map, written on a PHI2 edge when _CSW=0:
  - 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN.
  - 5 CTRL: bit0 START (self-clearing), bit1 IRQ_CLR, bit2 HOLD_SRC (see Optional Feature).
  - 6 and 7 are ignored.
- Writes to 0-4 while BUSY=1 are ignored. A START while BUSY=1 is ignored.
- IRQ_CLR clears IRQ in any state. START in IDLE also clears IRQ.
- State machine:
  - IDLE: START -> REQ; BUSY=1; latch the working copies SRCP, DSTP, CNT from the registers.
  - REQ: _DMA=0. When BA=1 is sampled -> RD. If REQ_TIMEOUT!=0 and the wait counter reaches REQ_TIMEOUT -> DONE with ABORT=1.
  - RD: BUS_OE=1, A_OUT=SRCP, R_W_OUT=1. At the end of the cycle, latch D_IN into the data register -> WR.
  - WR: A_OUT=DSTP, R_W_OUT=0, D_OUT=data register. At the end of the cycle:
    - increment DSTP and SRCP (16-bit, FFFF wraps to 0000);
    - decrement CNT; if CNT was 1 -> DONE, else -> RD.
  - DONE: BUS_OE=0, R_W_OUT=1, _DMA=1, BUSY=0, IRQ=1 -> IDLE.
- Latency and throughput:
  - One byte per two PHI2 cycles after grant.
  - From START to the first RD: 1 cycle + grant latency (the MMU grants at the next SYNC).
  - From the final WR to _DMA=1: 1 cycle.
- LEN=0 copies 256 bytes (CNT_W=8).
- If BA drops during RD/WR, the FSM stalls in the current state with outputs held. It resumes when BA returns; no cycle is skipped or repeated.
- Overlapping source/destination ranges copy forward only; the result is as for byte-by-byte ascending order.
- Working pointers are not written back; the registers keep their programmed values, so re-issuing START repeats the transfer.

Optional Feature:
- Macro LC256_DMA_FILL_EN.
- Defined: CTRL bit2 HOLD_SRC=1 keeps SRCP constant, so one source byte is re-read each pair. This produces a memory fill (e.g. from a ROM constant).
- Undefined: bit2 is ignored and SRCP always increments.

Decomposition:
- Shared package lc256_pkg holds:
  - register offsets (REG_SRC_L..REG_CTRL) and CTRL bit positions;
  - the state enum (IDLE, REQ, RD, WR, DONE).
- No sub-module: pointers, counter and FSM stay in lc256_dma.

Test Plan:
- Copy 4 bytes: SRC=$2000, DST=$3000, LEN=4, START, BA asserted 3 cycles after _DMA=0 -> alternating RD $2000 / WR $3000 … RD $2003 / WR $3003 with matching data; then _DMA=1, IRQ=1, BUSY=0.
- LEN=0 -> exactly 256 WR cycles, last WR address DST+$FF.
- Address wrap: SRC=$FFFE, LEN=3 -> reads at $FFFE, $FFFF, $0000.
- BA held 0 with REQ_TIMEOUT=255 -> after 255 cycles: _DMA=1, IRQ=1, no BUS_OE pulse. Then IRQ_CLR -> IRQ=0.
- RESET asserted during the 2nd WR -> next cycle: _DMA=1, BUS_OE=0, BUSY=0; registers read back as 0 behaviour (a new START with LEN=0 copies 256 bytes from $0000).
- With LC256_DMA_FILL_EN, HOLD_SRC=1, SRC=$E000 (holding $AA), LEN=8 -> 8 writes of $AA, every RD at $E000. Without the macro, SRC increments.
